// File: rtl/opendap_swd_host_serial_comms.sv
// Host-side SWD serial engine: turns one parallel request into an SWD packet
// (header, turnarounds, ACK, data phase with parity, trailing idle), re-issues
// requests that receive WAIT, and can emit a line-reset sequence.
module opendap_swd_host_serial_comms #(
    parameter int RETRY_LIMIT = 15,
    parameter int IDLE_CYCLES = 2
) (
    input  logic        swclk,
    input  logic        rst_n,
    output logic        swdo,
    output logic        swdo_en,
    input  logic        swdi,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cmd,
    input  logic        req_ap_ndp,
    input  logic        req_r_nw,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [2:0]  rsp_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_parity_err,
    output logic [3:0]  rsp_retries
);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LRESET     = 4'd1,
        ST_HEADER     = 4'd2,
        ST_TURN_ACK   = 4'd3,
        ST_ACK        = 4'd4,
        ST_TURN_WDATA = 4'd5,
        ST_WDATA      = 4'd6,
        ST_RDATA      = 4'd7,
        ST_TURN_RDATA = 4'd8,
        ST_TAIL_IDLE  = 4'd9
    } state_t;

    localparam logic [2:0] ACK_OK      = 3'b001;
    localparam logic [2:0] ACK_WAIT    = 3'b010;
    localparam logic [1:0] CMD_LRESET  = 2'd1;
    localparam logic [1:0] CMD_TSEL    = 2'd2;
    localparam logic [5:0] HDR_LAST    = 6'd7;
    localparam logic [5:0] ACK_LAST    = 6'd2;
    localparam logic [5:0] DATA_LAST   = 6'd32;
    localparam logic [5:0] LRESET_ONES = 6'd50;
    localparam logic [5:0] LRESET_LAST = 6'd51;
    localparam logic [5:0] TAIL_LAST   = 6'(IDLE_CYCLES - 1);
    localparam logic [3:0] RETRY_MAX   = (RETRY_LIMIT > 15) ? 4'd15 : 4'(RETRY_LIMIT);

    // Packet header as sent on the wire, bit 0 first.
    function automatic logic [7:0] swd_header(input logic ap_ndp, input logic r_nw,
                                              input logic [1:0] addr);
        logic par;
        par = ap_ndp ^ r_nw ^ addr[0] ^ addr[1];
        return {1'b1, 1'b0, par, addr[1], addr[0], r_nw, ap_ndp, 1'b1};
    endfunction

    // Even parity over a 32-bit data word.
    function automatic logic even_parity32(input logic [31:0] data);
        return ^data;
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        cmd_ts_q, cmd_ts_d;
    logic        ap_ndp_q, ap_ndp_d;
    logic        r_nw_q, r_nw_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rpar_q, rpar_d;

    logic        swdo_q, swdo_d;
    logic        swdo_en_q, swdo_en_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [2:0]  rsp_ack_q, rsp_ack_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_parity_err_q, rsp_parity_err_d;
    logic [3:0]  rsp_retries_q, rsp_retries_d;

    logic        retry_s;
    logic        read_ok_s;
    logic        write_phase_s;
    logic [7:0]  hdr_s;

    // Sequencing: next state, bit counter, captured request and sampled target bits.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        cmd_ts_d  = cmd_ts_q;
        ap_ndp_d  = ap_ndp_q;
        r_nw_d    = r_nw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;
        rpar_d    = rpar_q;
        // TARGETSEL ignores the ACK and always proceeds to the write phase.
        write_phase_s = cmd_ts_q || (ack_q == ACK_OK);
        retry_s       = !cmd_ts_q && (ack_q == ACK_WAIT) && (retry_q < RETRY_MAX);
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cmd_ts_d = (req_cmd == CMD_TSEL);
                    ap_ndp_d = req_ap_ndp;
                    r_nw_d   = req_r_nw;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    retry_d  = 4'd0;
                    cnt_d    = 6'd0;
                    if (req_cmd == CMD_LRESET) begin
                        state_d = ST_LRESET;
                    end else begin
                        state_d = ST_HEADER;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LRESET: begin
                if (cnt_q == LRESET_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_HEADER: begin
                if (cnt_q == HDR_LAST) begin
                    state_d = ST_TURN_ACK;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_TURN_ACK: begin
                state_d = ST_ACK;
                cnt_d   = 6'd0;
            end
            ST_ACK: begin
                // Shift in from the top so the first wire bit lands in ack[0].
                ack_d = {swdi, ack_q[2:1]};
                if (cnt_q == ACK_LAST) begin
                    cnt_d = 6'd0;
                    if (!cmd_ts_q && (ack_d == ACK_OK) && r_nw_q) begin
                        state_d = ST_RDATA;
                    end else begin
                        state_d = ST_TURN_WDATA;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_TURN_WDATA: begin
                cnt_d = 6'd0;
                if (write_phase_s) begin
                    state_d = ST_WDATA;
                end else begin
                    state_d = ST_TAIL_IDLE;
                end
            end
            ST_WDATA: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = ST_TAIL_IDLE;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_RDATA: begin
                if (cnt_q == DATA_LAST) begin
                    rpar_d  = swdi;
                    state_d = ST_TURN_RDATA;
                    cnt_d   = 6'd0;
                end else begin
                    rdata_d = {swdi, rdata_q[31:1]};
                    cnt_d   = cnt_q + 6'd1;
                end
            end
            ST_TURN_RDATA: begin
                state_d = ST_TAIL_IDLE;
                cnt_d   = 6'd0;
            end
            ST_TAIL_IDLE: begin
                if (cnt_q == TAIL_LAST) begin
                    cnt_d = 6'd0;
                    if (retry_s) begin
                        state_d = ST_HEADER;
                        retry_d = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from where the sequencer is going.
    always_comb begin
        hdr_s            = swd_header(ap_ndp_d, r_nw_d, addr_d);
        swdo_d           = 1'b0;
        swdo_en_d        = 1'b0;
        req_ready_d      = (state_d == ST_IDLE);
        rsp_valid_d      = 1'b0;
        rsp_ack_d        = rsp_ack_q;
        rsp_rdata_d      = rsp_rdata_q;
        rsp_parity_err_d = rsp_parity_err_q;
        rsp_retries_d    = rsp_retries_q;
        read_ok_s        = !cmd_ts_q && (ack_q == ACK_OK) && r_nw_q;
        case (state_d)
            ST_LRESET: begin
                swdo_en_d = 1'b1;
                swdo_d    = (cnt_d < LRESET_ONES);
            end
            ST_HEADER: begin
                swdo_en_d = 1'b1;
                swdo_d    = hdr_s[cnt_d[2:0]];
            end
            ST_WDATA: begin
                swdo_en_d = 1'b1;
                if (cnt_d == DATA_LAST) begin
                    swdo_d = even_parity32(wdata_d);
                end else begin
                    swdo_d = wdata_d[cnt_d[4:0]];
                end
            end
            ST_TAIL_IDLE: begin
                swdo_en_d = 1'b1;
                swdo_d    = 1'b0;
            end
            default: begin
                swdo_en_d = 1'b0;
                swdo_d    = 1'b0;
            end
        endcase
        if ((state_d == ST_LRESET) && (cnt_d == LRESET_LAST)) begin
            rsp_valid_d      = 1'b1;
            rsp_ack_d        = ACK_OK;
            rsp_retries_d    = 4'd0;
            rsp_parity_err_d = 1'b0;
        end else if ((state_d == ST_TAIL_IDLE) && (cnt_d == TAIL_LAST) && !retry_s) begin
            rsp_valid_d   = 1'b1;
            rsp_ack_d     = cmd_ts_q ? ACK_OK : ack_q;
            rsp_retries_d = retry_q;
            if (read_ok_s) begin
                rsp_rdata_d      = rdata_q;
                rsp_parity_err_d = (rpar_q != even_parity32(rdata_q));
            end else begin
                rsp_parity_err_d = 1'b0;
            end
        end else begin
            rsp_valid_d = 1'b0;
        end
    end

    // State, datapath and output registers; reset aborts any packet at once.
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 6'd0;
            retry_q          <= 4'd0;
            cmd_ts_q         <= 1'b0;
            ap_ndp_q         <= 1'b0;
            r_nw_q           <= 1'b0;
            addr_q           <= 2'd0;
            wdata_q          <= 32'd0;
            ack_q            <= 3'd0;
            rdata_q          <= 32'd0;
            rpar_q           <= 1'b0;
            swdo_q           <= 1'b0;
            swdo_en_q        <= 1'b0;
            req_ready_q      <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_ack_q        <= 3'd0;
            rsp_rdata_q      <= 32'd0;
            rsp_parity_err_q <= 1'b0;
            rsp_retries_q    <= 4'd0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            retry_q          <= retry_d;
            cmd_ts_q         <= cmd_ts_d;
            ap_ndp_q         <= ap_ndp_d;
            r_nw_q           <= r_nw_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            ack_q            <= ack_d;
            rdata_q          <= rdata_d;
            rpar_q           <= rpar_d;
            swdo_q           <= swdo_d;
            swdo_en_q        <= swdo_en_d;
            req_ready_q      <= req_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_ack_q        <= rsp_ack_d;
            rsp_rdata_q      <= rsp_rdata_d;
            rsp_parity_err_q <= rsp_parity_err_d;
            rsp_retries_q    <= rsp_retries_d;
        end
    end

    assign swdo           = swdo_q;
    assign swdo_en        = swdo_en_q;
    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_ack        = rsp_ack_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_parity_err = rsp_parity_err_q;
    assign rsp_retries    = rsp_retries_q;

endmodule

// File: tb/tb_opendap_swd_host_serial_comms.sv
// Bench for the SWD host engine: a behavioural target/packet model builds the
// expected wire image and response for each request and compares the DUT.
module tb_opendap_swd_host_serial_comms;

    localparam int RL = 3;
    localparam int IC = 2;
    localparam logic [2:0] OK  = 3'b001;
    localparam logic [2:0] WT  = 3'b010;
    localparam logic [2:0] FLT = 3'b100;

    logic        swclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        swdo;
    logic        swdo_en;
    logic        swdi = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_cmd = 2'd0;
    logic        req_ap_ndp = 1'b0;
    logic        req_r_nw = 1'b0;
    logic [1:0]  req_addr = 2'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        rsp_parity_err;
    logic [3:0]  rsp_retries;

    always #5 swclk = ~swclk;

    opendap_swd_host_serial_comms #(.RETRY_LIMIT(RL), .IDLE_CYCLES(IC)) dut (
        .swclk(swclk), .rst_n(rst_n), .swdo(swdo), .swdo_en(swdo_en), .swdi(swdi),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_ap_ndp(req_ap_ndp), .req_r_nw(req_r_nw), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .rsp_rdata(rsp_rdata), .rsp_parity_err(rsp_parity_err), .rsp_retries(rsp_retries)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] m_rdata = 32'd0;
    logic exp_en[$];
    logic exp_do[$];
    logic tgt[$];
    logic obs_en[$];
    logic obs_do[$];
    logic [2:0] acks[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rb(input logic hi);
        return hi ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic en, input logic d, input logic t);
        exp_en.push_back(en);
        exp_do.push_back(d);
        tgt.push_back(t);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge swclk);
        end
    endtask

    task automatic run_xfer(input logic [1:0] cmd, input logic ap, input logic rnw,
                            input logic [1:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic flip, input logic fhi,
                            input int hdr_exp, input int abort_cyc, input string name);
        logic [1:0]  ec;
        logic        ts;
        logic [7:0]  hdr;
        logic [2:0]  a_ack;
        logic [2:0]  e_ack;
        logic [3:0]  e_ret;
        logic        e_perr;
        logic [31:0] e_rdata;
        logic [7:0]  obs_hdr;
        int          att;
        int          resp_idx;
        int          mism;
        int          n;
        bit          ok;
        exp_en.delete(); exp_do.delete(); tgt.delete(); obs_en.delete(); obs_do.delete();
        ec  = (cmd == 2'd3) ? 2'd0 : cmd;
        ts  = (ec == 2'd2);
        hdr = 8'(1 + 2 * ap + 4 * rnw + 8 * addr + 32 * (ap ^ rnw ^ addr[0] ^ addr[1]) + 128);
        e_rdata = m_rdata; e_perr = 1'b0; e_ret = 4'd0; e_ack = OK;
        if (ec == 2'd1) begin
            for (int i = 0; i < 50; i++) push(1'b1, 1'b1, rb(fhi));
            for (int i = 0; i < 2; i++) push(1'b1, 1'b0, rb(fhi));
        end else begin
            att = 0;
            forever begin
                a_ack = acks[(att < acks.size()) ? att : acks.size() - 1];
                for (int i = 0; i < 8; i++) push(1'b1, hdr[i], rb(fhi));
                push(1'b0, 1'b0, rb(fhi));
                for (int i = 0; i < 3; i++) push(1'b0, 1'b0, a_ack[i]);
                if (ts || (a_ack == OK && !rnw)) begin
                    push(1'b0, 1'b0, rb(fhi));
                    for (int i = 0; i < 32; i++) push(1'b1, wdata[i], rb(fhi));
                    push(1'b1, ^wdata, rb(fhi));
                end else if (a_ack == OK) begin
                    for (int i = 0; i < 32; i++) push(1'b0, 1'b0, rdata[i]);
                    push(1'b0, 1'b0, (^rdata) ^ flip);
                    push(1'b0, 1'b0, rb(fhi));
                end else begin
                    push(1'b0, 1'b0, rb(fhi));
                end
                for (int i = 0; i < IC; i++) push(1'b1, 1'b0, rb(fhi));
                if (!ts && a_ack == WT && att < RL) att++;
                else break;
            end
            e_ret = 4'(att);
            e_ack = ts ? OK : a_ack;
            if (!ts && a_ack == OK && rnw) begin
                e_rdata = rdata;
                e_perr  = flip;
            end
        end
        wait_ready(ok);
        check({name, "_ready"}, 64'(ok), 64'd1);
        if (!ok) return;
        req_cmd = cmd; req_ap_ndp = ap; req_r_nw = rnw; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge swclk);
        #1 req_valid = 1'b0;
        resp_idx = -1;
        for (int k = 0; k < exp_en.size() + 20; k++) begin
            @(negedge swclk);
            obs_en.push_back(swdo_en);
            obs_do.push_back(swdo);
            swdi = (k < tgt.size()) ? tgt[k] : rb(fhi);
            if (k == abort_cyc) begin
                check({name, "_pre_rst_en"}, 64'(swdo_en), 64'(exp_en[k]));
                #1 rst_n = 1'b0;
                #1;
                check("rst_swdo_en", 64'(swdo_en), 64'd0);
                check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
                check("rst_req_ready", 64'(req_ready), 64'd0);
                m_rdata = 32'd0;
                return;
            end
            if (rsp_valid === 1'b1) begin
                resp_idx = k;
                break;
            end
        end
        check({name, "_rsp_cycle"}, 64'(resp_idx), 64'(exp_en.size() - 1));
        mism = -1;
        n = (obs_en.size() < exp_en.size()) ? obs_en.size() : exp_en.size();
        for (int i = 0; i < n; i++) begin
            if (mism < 0 && (obs_en[i] !== exp_en[i] || (exp_en[i] && obs_do[i] !== exp_do[i])))
                mism = i;
        end
        check({name, "_wire_first_bad_cycle"}, 64'(mism), 64'(-1));
        check({name, "_ack"}, 64'(rsp_ack), 64'(e_ack));
        check({name, "_rdata"}, 64'(rsp_rdata), 64'(e_rdata));
        check({name, "_perr"}, 64'(rsp_parity_err), 64'(e_perr));
        check({name, "_retries"}, 64'(rsp_retries), 64'(e_ret));
        if (hdr_exp >= 0 && obs_do.size() >= 8) begin
            for (int i = 0; i < 8; i++) obs_hdr[i] = obs_do[i];
            check({name, "_header"}, 64'(obs_hdr), 64'(hdr_exp));
        end
        m_rdata = e_rdata;
        @(negedge swclk);
        check({name, "_rsp_pulse_end"}, 64'(rsp_valid), 64'd0);
        check({name, "_rsp_hold"}, 64'(rsp_ack), 64'(e_ack));
    endtask

    initial begin
        int nacks;
        logic [2:0] pick;
        #12;
        check("rst_swdo", 64'(swdo), 64'd0);
        check("rst_swdo_en0", 64'(swdo_en), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_ack", 64'(rsp_ack), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_perr", 64'(rsp_parity_err), 64'd0);
        check("rst_retries", 64'(rsp_retries), 64'd0);
        @(negedge swclk);
        rst_n = 1'b1;
        @(posedge swclk);
        @(negedge swclk);
        check("ready_after_rst", 64'(req_ready), 64'd1);

        acks = '{OK};
        run_xfer(2'd0, 1'b0, 1'b0, 2'd2, 32'h0000_00F0, 32'd0, 1'b0, 1'b0, 'hB1, -1, "dp_write");
        run_xfer(2'd0, 1'b0, 1'b1, 2'd0, 32'd0, 32'h0BC1_2477, 1'b0, 1'b0, 'hA5, -1, "dpidr");
        run_xfer(2'd0, 1'b0, 1'b1, 2'd0, 32'd0, 32'h0BC1_2477, 1'b1, 1'b0, 'hA5, -1, "dpidr_bad_par");
        acks = '{WT, WT, OK};
        run_xfer(2'd0, 1'b1, 1'b1, 2'd1, 32'd0, 32'h1234_5678, 1'b0, 1'b0, -1, -1, "ap_wait2");
        acks = '{WT};
        run_xfer(2'd0, 1'b1, 1'b1, 2'd3, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, -1, -1, "wait_limit");
        run_xfer(2'd1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, -1, -1, "line_reset");
        acks = '{3'b111};
        run_xfer(2'd2, 1'b0, 1'b0, 2'd3, 32'h0100_2927, 32'd0, 1'b0, 1'b1, 'h99, -1, "targetsel");
        acks = '{FLT};
        run_xfer(2'd0, 1'b1, 1'b0, 2'd1, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0, -1, -1, "fault_write");
        acks = '{3'b111};
        run_xfer(2'd3, 1'b1, 1'b1, 2'd2, 32'd0, 32'hFFFF_0000, 1'b0, 1'b1, -1, -1, "no_target");

        for (int t = 0; t < 30; t++) begin
            acks.delete();
            nacks = $urandom_range(1, 4);
            for (int i = 0; i < nacks; i++) begin
                case ($urandom_range(0, 5))
                    0, 1: pick = OK;
                    2: pick = WT;
                    3: pick = FLT;
                    4: pick = 3'b111;
                    default: pick = 3'($urandom);
                endcase
                acks.push_back(pick);
            end
            run_xfer(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 2'($urandom),
                     $urandom, $urandom, 1'($urandom), 1'b0, -1, -1, "rand");
        end

        acks = '{OK};
        run_xfer(2'd0, 1'b0, 1'b0, 2'd1, 32'h5A5A_A5A5, 32'd0, 1'b0, 1'b0, -1, 20, "abort_write");
        repeat (3) @(negedge swclk);
        check("abort_no_rsp", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 64'(req_ready), 64'd0);
        @(posedge swclk);
        @(negedge swclk);
        check("ready_one_cycle_after_rst", 64'(req_ready), 64'd1);
        check("rdata_cleared", 64'(rsp_rdata), 64'd0);
        run_xfer(2'd0, 1'b0, 1'b1, 2'd0, 32'd0, 32'h0BC1_2477, 1'b0, 1'b0, 'hA5, -1, "recover_read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/opendap_swd_host_serial_comms.md
Name: opendap_swd_host_serial_comms

Overview:
Host-side (initiator) SWD serial engine, the probe end of the SW-DP link. It accepts parallel transfer requests, serialises the 8-bit packet header, samples the target ACK and handles read/write data phases with parity. It retries automatically on WAIT and issues line-reset sequences on command. It sits between the probe's command FIFO/CPU interface and the SWDIO pad (swdo/swdo_en/swdi).

Parameters:
RETRY_LIMIT, 15, maximum automatic re-issues of a request after WAIT ACKs (0 = never retry)
IDLE_CYCLES, 2, swdo=0 idle cycles driven after every transfer, including between retries (≥1)

Ports:
swclk  input  1  SWD clock; one bit per cycle
rst_n  input  1  reset, asynchronous, active-low
swdo  output  1  serial data to pad
swdo_en  output  1  pad output enable (1 = host drives)
swdi  input  1  serial data from pad, sampled on swclk posedge
req_valid  input  1  request present
req_ready  output  1  engine can accept request
req_cmd  input  2  0 = transfer, 1 = line reset, 2 = TARGETSEL-style transfer (ACK ignored), 3 = reserved (treated as 0)
req_ap_ndp  input  1  header APnDP
req_r_nw  input  1  header RnW
req_addr  input  2  header A[3:2]
req_wdata  input  32  write data
rsp_valid  output  1  one-cycle response pulse
rsp_ack  output  3  ACK as sampled, first wire bit in [0] (OK=3'b001, WAIT=3'b010, FAULT=3'b100)
rsp_rdata  output  32  read data
rsp_parity_err  output  1  read data parity mismatch
rsp_retries  output  4  WAIT retries consumed

Behaviour:
- Reset: swdo=0, swdo_en=0, req_ready=0, rsp_valid=0, rsp_ack=0, rsp_rdata=0, rsp_parity_err=0, rsp_retries=0, state IDLE. All outputs are registered.
- Reset mid-operation aborts immediately (swdo_en=0 asynchronously). No response is produced.
- Handshake: req_ready=1 only in IDLE. A request is accepted on req_valid&&req_ready and all req_* fields are captured. A new request is only accepted once the previous response has completed.
- rsp_valid: no backpressure. rsp_* fields hold until the next response.
- States: IDLE, LRESET, HEADER, TURN_ACK, ACK, TURN_WDATA, WDATA, RDATA, TURN_RDATA, TAIL_IDLE. A 6-bit counter plus a retry counter track progress.
- Cycle numbering: cycle 0 is the first swclk cycle after acceptance.
- HEADER (cycles 0-7, swdo_en=1):
  - Bits LSB-first: 1, APnDP, RnW, A2, A3, parity=APnDP^RnW^A2^A3, 0, 1.
  - DPIDR read = 0xA5; TARGETSEL write = 0x99.
- TURN_ACK (cycle 8): swdo_en=0.
- ACK (cycles 9-11): swdi sampled into ack[0..2]. swdo_en=0.
- Write with OK ACK:
  - Cycle 12: turnaround, swdo_en=0.
  - Cycles 13-44: wdata LSB-first, swdo_en=1.
  - Cycle 45: even parity of wdata.
  - Then TAIL_IDLE.
- Read with OK ACK:
  - Cycles 12-43: sample rdata LSB-first.
  - Cycle 44: sample parity; rsp_parity_err = parity bit != ^rdata.
  - Cycle 45: turnaround, swdo_en=0.
  - Then TAIL_IDLE.
- TAIL_IDLE: IDLE_CYCLES cycles of swdo=0, swdo_en=1. rsp_valid pulses in the final TAIL_IDLE cycle, then state returns to IDLE.
- WAIT ACK:
  - Sequence: one turnaround cycle, then TAIL_IDLE.
  - If retries < RETRY_LIMIT: increment retries and restart at HEADER with the same captured request, with no rsp_valid.
  - Otherwise: respond with rsp_ack=3'b010.
- FAULT or any other ACK (including 3'b111, no target): one turnaround cycle, TAIL_IDLE, then respond with the sampled ACK. rsp_rdata is unchanged. No data phase.
- req_cmd=2 (TARGETSEL):
  - Header as above.
  - Cycles 8-12 have swdo_en=0; ACK is ignored.
  - Data driven as for an OK write.
  - Response: rsp_ack=3'b001.
- req_cmd=1 (line reset):
  - 50 cycles of swdo=1, then 2 cycles of swdo=0, swdo_en=1 throughout.
  - No TAIL_IDLE.
  - Response: rsp_ack=3'b001, rsp_retries=0.
- rsp_retries saturates at 15 and is cleared on each accepted request.

Test Plan:
- DP write SELECT (ap_ndp=0, r_nw=0, addr=2, wdata=0x000000F0), target ACK OK -> header 0xB1 LSB-first; swdo_en=0 in cycles 8-12; cycles 13-44 carry 0x000000F0; parity bit 0; rsp_ack=001.
- DPIDR read (header 0xA5), target returns OK and 0x0BC12477 with correct parity -> rsp_rdata=0x0BC12477, rsp_parity_err=0. Repeat with parity inverted -> rsp_parity_err=1.
- AP read, target returns WAIT twice then OK -> header reissued three times, each separated by IDLE_CYCLES zeros; single rsp_valid; rsp_retries=2, rsp_ack=001.
- RETRY_LIMIT=3, target always WAIT -> exactly 4 headers sent; rsp_ack=010, rsp_retries=3.
- Line reset followed by TARGETSEL 0x01002927 with swdi floating high -> 50 ones, 2 zeros; header 0x99; data and parity driven regardless of ACK; rsp_ack=001.
- rst_n asserted in cycle 20 of a write -> swdo_en=0 immediately; no rsp_valid; req_ready=1 one cycle after rst_n deasserts.
